// File: rtl/sap_pkg.sv
// Shared definitions for the SAP controller: opcodes, state encodings and
// control-word bit positions.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        MODE_INIT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam int CW_PC_EN   = 0;
    localparam int CW_PC_INC  = 1;
    localparam int CW_PC_CLR  = 2;
    localparam int CW_MAR_LD  = 3;
    localparam int CW_RAM_EN  = 4;
    localparam int CW_IR_LD   = 5;
    localparam int CW_IR_EN   = 6;
    localparam int CW_A_LD    = 7;
    localparam int CW_A_EN    = 8;
    localparam int CW_B_LD    = 9;
    localparam int CW_ALU_SUB = 10;
    localparam int CW_ALU_EN  = 11;
    localparam int CW_OUT_LD  = 12;
    localparam int CW_HALT    = 13;
    localparam int CW_W       = 14;

    // The ring only carries T1..T6; INIT and HALT come from the mode register.
    function automatic state_e decode_state(input mode_e mode, input logic [5:0] t);
        state_e st;
        st = ST_INIT;
        case (mode)
            MODE_INIT: st = ST_INIT;
            MODE_HALT: st = ST_HALT;
            MODE_RUN: begin
                case (t)
                    6'b000001: st = ST_T1;
                    6'b000010: st = ST_T2;
                    6'b000100: st = ST_T3;
                    6'b001000: st = ST_T4;
                    6'b010000: st = ST_T5;
                    6'b100000: st = ST_T6;
                    default:   st = ST_INIT;
                endcase
            end
            default: st = ST_INIT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring. An all-zero ring starts at T1 on the first advance;
// clear returns it to all-zero.
module sap_ring_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         advance_i,
    output logic [N-1:0] t_o
);

    logic [N-1:0] t_q;
    logic [N-1:0] t_d;

    // Next ring value: clear, start, rotate or hold.
    always_comb begin
        t_d = t_q;
        if (clear_i) begin
            t_d = {N{1'b0}};
        end else if (advance_i) begin
            if (t_q == {N{1'b0}}) begin
                t_d = {{(N-1){1'b0}}, 1'b1};
            end else begin
                t_d = {t_q[N-2:0], t_q[N-1]};
            end
        end else begin
            t_d = t_q;
        end
    end

    // Ring register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= {N{1'b0}};
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: INIT/HALT handling, T4-T6 opcode decode and the
// control word. Optional single-step input is enabled by defining SAP_STEP_EN.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6
) (
    input  logic                clk,
    input  logic                clr_n,
`ifdef SAP_STEP_EN
    input  logic                step,
`endif
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_en,
    output logic                pc_inc,
    output logic                pc_clr,
    output logic                mar_ld,
    output logic                ram_en,
    output logic                ir_ld,
    output logic                ir_en,
    output logic                a_ld,
    output logic                a_en,
    output logic                b_ld,
    output logic                alu_sub,
    output logic                alu_en,
    output logic                out_ld,
    output logic                halt,
    output logic [NUM_T-1:0]    t_state
);

    mode_e             mode_q;
    mode_e             mode_d;
    logic [NUM_T-1:0]  ring_s;
    state_e            state_s;
    logic              advance_s;
    logic              halt_entry_s;
    logic              out_gate_s;
    logic [CW_W-1:0]   cw_s;

`ifdef SAP_STEP_EN
    assign advance_s = step;
`else
    assign advance_s = 1'b1;
`endif

    assign state_s      = decode_state(mode_q, ring_s);
    assign halt_entry_s = (state_s == ST_T4) && (opcode == OP_HLT);
    // Reset and a held single-step both silence every control line.
    assign out_gate_s   = clr_n & advance_s;

    sap_ring_counter #(.N(NUM_T)) u_ring (
        .clk       (clk),
        .rst_n     (clr_n),
        .clear_i   (advance_s & halt_entry_s),
        .advance_i (advance_s & (mode_q != MODE_HALT) & ~halt_entry_s),
        .t_o       (ring_s)
    );

    // Mode register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_q <= MODE_INIT;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode transitions: INIT runs once, HLT in T4 parks the machine.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_INIT: begin
                if (advance_s) mode_d = MODE_RUN;
                else           mode_d = mode_q;
            end
            MODE_RUN: begin
                if (advance_s && halt_entry_s) mode_d = MODE_HALT;
                else                           mode_d = mode_q;
            end
            MODE_HALT: mode_d = MODE_HALT;
            default:   mode_d = MODE_INIT;
        endcase
    end

    // Control word decode from state and opcode.
    always_comb begin
        cw_s = {CW_W{1'b0}};
        case (state_s)
            ST_INIT: begin cw_s[CW_PC_EN] = 1'b1; cw_s[CW_PC_CLR] = 1'b1; end
            ST_T1:   begin cw_s[CW_PC_EN] = 1'b1; cw_s[CW_MAR_LD] = 1'b1; end
            ST_T2:   begin cw_s[CW_PC_EN] = 1'b1; cw_s[CW_PC_INC] = 1'b1; end
            ST_T3:   begin cw_s[CW_RAM_EN] = 1'b1; cw_s[CW_IR_LD] = 1'b1; end
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw_s[CW_IR_EN] = 1'b1; cw_s[CW_MAR_LD] = 1'b1;
                    end
                    OP_OUT:  begin cw_s[CW_A_EN] = 1'b1; cw_s[CW_OUT_LD] = 1'b1; end
                    OP_HLT:  cw_s[CW_HALT] = 1'b1;
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LDA:  begin cw_s[CW_RAM_EN] = 1'b1; cw_s[CW_A_LD] = 1'b1; end
                    OP_ADD:  begin cw_s[CW_RAM_EN] = 1'b1; cw_s[CW_B_LD] = 1'b1; end
                    OP_SUB: begin
                        cw_s[CW_RAM_EN] = 1'b1; cw_s[CW_B_LD] = 1'b1; cw_s[CW_ALU_SUB] = 1'b1;
                    end
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OP_ADD:  begin cw_s[CW_ALU_EN] = 1'b1; cw_s[CW_A_LD] = 1'b1; end
                    OP_SUB: begin
                        cw_s[CW_ALU_EN] = 1'b1; cw_s[CW_A_LD] = 1'b1; cw_s[CW_ALU_SUB] = 1'b1;
                    end
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_HALT: cw_s[CW_HALT] = 1'b1;
            default: cw_s = {CW_W{1'b0}};
        endcase
    end

    assign pc_en   = cw_s[CW_PC_EN]   & out_gate_s;
    assign pc_inc  = cw_s[CW_PC_INC]  & out_gate_s;
    assign pc_clr  = cw_s[CW_PC_CLR]  & out_gate_s;
    assign mar_ld  = cw_s[CW_MAR_LD]  & out_gate_s;
    assign ram_en  = cw_s[CW_RAM_EN]  & out_gate_s;
    assign ir_ld   = cw_s[CW_IR_LD]   & out_gate_s;
    assign ir_en   = cw_s[CW_IR_EN]   & out_gate_s;
    assign a_ld    = cw_s[CW_A_LD]    & out_gate_s;
    assign a_en    = cw_s[CW_A_EN]    & out_gate_s;
    assign b_ld    = cw_s[CW_B_LD]    & out_gate_s;
    assign alu_sub = cw_s[CW_ALU_SUB] & out_gate_s;
    assign alu_en  = cw_s[CW_ALU_EN]  & out_gate_s;
    assign out_ld  = cw_s[CW_OUT_LD]  & out_gate_s;
    assign halt    = cw_s[CW_HALT]    & out_gate_s;
    assign t_state = ring_s;

endmodule

// File: tb/tb_sap_controller.sv
// Directed, table-driven bench for sap_controller (default build).
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] opcode;
    logic       pc_en, pc_inc, pc_clr, mar_ld, ram_en, ir_ld, ir_en;
    logic       a_ld, a_en, b_ld, alu_sub, alu_en, out_ld, halt;
    logic [5:0] t_state;
    logic [13:0] cw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap_controller dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .opcode  (opcode),
        .pc_en   (pc_en),
        .pc_inc  (pc_inc),
        .pc_clr  (pc_clr),
        .mar_ld  (mar_ld),
        .ram_en  (ram_en),
        .ir_ld   (ir_ld),
        .ir_en   (ir_en),
        .a_ld    (a_ld),
        .a_en    (a_en),
        .b_ld    (b_ld),
        .alu_sub (alu_sub),
        .alu_en  (alu_en),
        .out_ld  (out_ld),
        .halt    (halt),
        .t_state (t_state)
    );

    assign cw = {pc_en, pc_inc, pc_clr, mar_ld, ram_en, ir_ld, ir_en,
                 a_ld, a_en, b_ld, alu_sub, alu_en, out_ld, halt};

    localparam logic [13:0] PCE  = 14'b10000000000000;
    localparam logic [13:0] INC  = 14'b01000000000000;
    localparam logic [13:0] CLR  = 14'b00100000000000;
    localparam logic [13:0] MAR  = 14'b00010000000000;
    localparam logic [13:0] RAM  = 14'b00001000000000;
    localparam logic [13:0] IRL  = 14'b00000100000000;
    localparam logic [13:0] IRE  = 14'b00000010000000;
    localparam logic [13:0] AL   = 14'b00000001000000;
    localparam logic [13:0] AE   = 14'b00000000100000;
    localparam logic [13:0] BL   = 14'b00000000010000;
    localparam logic [13:0] SUBM = 14'b00000000001000;
    localparam logic [13:0] ALE  = 14'b00000000000100;
    localparam logic [13:0] OUL  = 14'b00000000000010;
    localparam logic [13:0] HLTM = 14'b00000000000001;
    localparam logic [13:0] NONE = 14'b00000000000000;

    localparam logic [5:0] T0 = 6'b000000;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct {
        logic        c;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [13:0] w;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic c, input logic [3:0] op, input logic [5:0] t, input logic [13:0] w);
        vec_t v;
        v.c = c; v.op = op; v.t = t; v.w = w;
        vecs.push_back(v);
    endtask

    // Fetch runs with a scrambled opcode to show T1-T3 ignore it.
    task automatic add_instr(input logic [3:0] op, input logic [13:0] w4,
                             input logic [13:0] w5, input logic [13:0] w6);
        logic [3:0] junk;
        junk = op ^ 4'b1111;
        add(1'b1, junk, T1, PCE | MAR);
        add(1'b1, junk, T2, PCE | INC);
        add(1'b1, junk, T3, RAM | IRL);
        add(1'b1, op,   T4, w4);
        add(1'b1, op,   T5, w5);
        add(1'b1, op,   T6, w6);
    endtask

    task automatic sample(input string nm, input logic [5:0] t_exp, input logic [13:0] w_exp);
        chk({nm, "_t"},  {26'd0, t_state}, {26'd0, t_exp});
        chk({nm, "_cw"}, {18'd0, cw},      {18'd0, w_exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        @(negedge clk);
        clr_n = 1'b1;
        #1;
    endtask

    initial begin
        clr_n  = 1'b0;
        opcode = 4'd0;

        add(1'b0, 4'd0, T0, NONE);
        add(1'b1, 4'd0, T0, PCE | CLR);
        add_instr(4'b0000, IRE | MAR, RAM | AL,        NONE);
        add_instr(4'b0001, IRE | MAR, RAM | BL,        ALE | AL);
        add_instr(4'b0010, IRE | MAR, RAM | BL | SUBM, ALE | AL | SUBM);
        add_instr(4'b1110, AE | OUL,  NONE,            NONE);
        add_instr(4'b0101, NONE,      NONE,            NONE);
        add_instr(4'b1100, NONE,      NONE,            NONE);
        add(1'b1, 4'b0000, T1, PCE | MAR);
        add(1'b1, 4'b0000, T2, PCE | INC);
        add(1'b1, 4'b0000, T3, RAM | IRL);
        add(1'b1, 4'b1111, T4, HLTM);
        add(1'b1, 4'b0000, T0, HLTM);
        add(1'b1, 4'b0011, T0, HLTM);
        add(1'b1, 4'b1111, T0, HLTM);

        foreach (vecs[i]) begin
            @(negedge clk);
            clr_n  = vecs[i].c;
            opcode = vecs[i].op;
            #1;
            sample($sformatf("vec%0d", i), vecs[i].t, vecs[i].w);
        end

        // LDA loop: T1 recurs every 6 clocks for 10 instructions.
        begin
            int t1_at[11];
            int found;
            found = 0;
            foreach (t1_at[k]) t1_at[k] = 0;
            opcode = 4'b0000;
            do_reset();
            for (int c = 1; c <= 80 && found < 11; c++) begin
                @(negedge clk);
                #1;
                if (t_state == T1) begin
                    t1_at[found] = c;
                    found++;
                end
            end
            chk("first_t1", t1_at[0], 1);
            for (int k = 1; k < 11; k++) chk($sformatf("period%0d", k), t1_at[k] - t1_at[k-1], 6);
        end

        // HLT: halted within 5 cycles of INIT, then parked for 20 cycles.
        begin
            int w;
            w = 0;
            opcode = 4'b1111;
            do_reset();
            while (!(halt === 1'b1 && t_state === T0) && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("halt_latency", w, 5);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                #1;
                sample("halt_hold", T0, HLTM);
            end
            opcode = 4'b0000;
            @(negedge clk);
            clr_n = 1'b0;
            #1;
            sample("halt_clr", T0, NONE);
            @(negedge clk);
            clr_n = 1'b1;
            #1;
            sample("halt_init", T0, PCE | CLR);
            @(negedge clk);
            #1;
            sample("halt_t1", T1, PCE | MAR);
        end

        // Async reset in the middle of ADD's T5.
        opcode = 4'b0001;
        do_reset();
        repeat (5) @(negedge clk);
        #1;
        sample("add_t5", T5, RAM | BL);
        #2;
        clr_n = 1'b0;
        #1;
        sample("mid_clr", T0, NONE);
        @(negedge clk);
        #1;
        sample("clr_held", T0, NONE);
        clr_n = 1'b1;
        #1;
        sample("re_init", T0, PCE | CLR);
        @(negedge clk);
        #1;
        sample("re_t1", T1, PCE | MAR);

        // Random opcodes: bus drivers never collide.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            clr_n  = (halt === 1'b1 && t_state === T0) ? 1'b0 : 1'b1;
            opcode = 4'($urandom_range(0, 15));
            #1;
            chk("bus_onehot", {31'd0, ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) <= 1)}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
